// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the bus datapath strobes.
// Latency: Moore outputs, one state per cycle; 5-9 cycles per instruction plus memory wait.
// Backpressure: stalls in memory wait states until MFC, aborting to HLT after MEM_TIMEOUT cycles.
module control_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] IR,
   input  logic        MFC,
   output logic        ALUin1,
   output logic        ALUin2,
   output logic        ALU_outlach,
   output logic        ALU_outEN,
   output logic        G0_in,
   output logic        G1_in,
   output logic        G2_in,
   output logic        G3_in,
   output logic        G0_out,
   output logic        G1_out,
   output logic        G2_out,
   output logic        G3_out,
   output logic        PC_Out,
   output logic        PC_inc,
   output logic        P0_in,
   output logic        P1_in,
   output logic        P1_out,
   output logic        P0_out,
   output logic        mem_EN,
   output logic        mem_RW,
   output logic        MAR_EN,
   output logic        MDR_EN_write,
   output logic        MDR_EN_read,
   output logic        MDR_out,
   output logic        IR_EN,
   output logic        immediate_out,
   output logic [15:0] imm_value,
   output logic        halted,
   output logic        mem_err
);

   typedef enum logic [4:0] {
      ST_F0, ST_F1, ST_F2, ST_F3, ST_DEC,
      ST_A0, ST_A1, ST_A2, ST_A3,
      ST_L0, ST_L1, ST_L2, ST_L3,
      ST_S0, ST_S1, ST_S2,
      ST_I0, ST_I1, ST_O0, ST_M0,
      ST_HLT
   } state_t;

   // Last wait-cycle index; MFC still low here means the access has timed out.
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_nx;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nx;
   logic       wait_expired;
   logic       timeout_hit;
   logic [3:0] rd_oh;
   logic [3:0] ra_oh;
   logic [3:0] rb_oh;
   logic [3:0] g_in;
   logic [3:0] g_out;

   // Register-field decode; only consumed in DEC and execute states.
   assign rd_oh = 4'b0001 << IR[11:10];
   assign ra_oh = 4'b0001 << IR[9:8];
   assign rb_oh = 4'b0001 << IR[7:6];

   // Immediate is a pure function of IR so the datapath sees it without delay.
   assign imm_value = {{8{IR[7]}}, IR[7:0]};

   assign wait_expired = !MFC && (wait_cnt == TO_LAST);

   // State, wait counter and sticky status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_F0;
         wait_cnt <= 8'd0;
         halted   <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (state_nx == ST_HLT) begin
            halted <= 1'b1;
         end
         if (timeout_hit) begin
            mem_err <= 1'b1;
         end
      end
   end

   // Next-state: the wait counter is cleared on every transition into a wait state.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      timeout_hit = 1'b0;
      case (state)
         ST_F0: begin
            state_nx    = ST_F1;
            wait_cnt_nx = 8'd0;
         end
         ST_F1, ST_L1, ST_S2: begin
            if (MFC) begin
               case (state)
                  ST_F1:   state_nx = ST_F2;
                  ST_L1:   state_nx = ST_L2;
                  default: state_nx = ST_F0;
               endcase
            end else if (wait_expired) begin
               state_nx    = ST_HLT;
               timeout_hit = 1'b1;
            end else begin
               wait_cnt_nx = wait_cnt + 8'd1;
            end
         end
         ST_F2: state_nx = ST_F3;
         ST_F3: state_nx = ST_DEC;
         ST_DEC: begin
            if (IR[15]) begin
               state_nx = ST_A0;
            end else begin
               case (IR[14:12])
                  3'b001:  state_nx = ST_L0;
                  3'b010:  state_nx = ST_S0;
                  3'b011:  state_nx = ST_I0;
                  3'b100:  state_nx = ST_O0;
                  3'b101:  state_nx = ST_M0;
                  3'b110:  state_nx = ST_HLT;
                  default: state_nx = ST_F0;
               endcase
            end
         end
         ST_A0: state_nx = ST_A1;
         ST_A1: state_nx = ST_A2;
         ST_A2: state_nx = ST_A3;
         ST_A3: state_nx = ST_F0;
         ST_L0: begin
            state_nx    = ST_L1;
            wait_cnt_nx = 8'd0;
         end
         ST_L2: state_nx = ST_L3;
         ST_L3: state_nx = ST_F0;
         ST_S0: state_nx = ST_S1;
         ST_S1: begin
            state_nx    = ST_S2;
            wait_cnt_nx = 8'd0;
         end
         ST_I0:  state_nx = ST_I1;
         ST_I1:  state_nx = ST_F0;
         ST_O0:  state_nx = ST_F0;
         ST_M0:  state_nx = ST_F0;
         ST_HLT: state_nx = ST_HLT;
         default: state_nx = ST_HLT;
      endcase
   end

   // Moore strobe decode; everything reads 0 while reset is asserted.
   always_comb begin
      ALUin1        = 1'b0;
      ALUin2        = 1'b0;
      ALU_outlach   = 1'b0;
      ALU_outEN     = 1'b0;
      PC_Out        = 1'b0;
      PC_inc        = 1'b0;
      P0_in         = 1'b0;
      P1_in         = 1'b0;
      P1_out        = 1'b0;
      mem_EN        = 1'b0;
      mem_RW        = 1'b0;
      MAR_EN        = 1'b0;
      MDR_EN_write  = 1'b0;
      MDR_EN_read   = 1'b0;
      MDR_out       = 1'b0;
      IR_EN         = 1'b0;
      immediate_out = 1'b0;
      g_in          = 4'b0000;
      g_out         = 4'b0000;
      if (rst) begin
         case (state)
            ST_F0: begin
               PC_Out = 1'b1;
               MAR_EN = 1'b1;
            end
            ST_F1, ST_L1: begin
               mem_EN = 1'b1;
               mem_RW = 1'b1;
            end
            ST_F2, ST_L2: MDR_EN_read = 1'b1;
            ST_F3: begin
               MDR_out = 1'b1;
               IR_EN   = 1'b1;
               PC_inc  = 1'b1;
            end
            ST_A0: begin
               g_out  = ra_oh;
               ALUin1 = 1'b1;
            end
            ST_A1: begin
               g_out  = rb_oh;
               ALUin2 = 1'b1;
            end
            ST_A2: ALU_outlach = 1'b1;
            ST_A3: begin
               ALU_outEN = 1'b1;
               g_in      = rd_oh;
            end
            ST_L0, ST_S0: begin
               g_out  = ra_oh;
               MAR_EN = 1'b1;
            end
            ST_L3: begin
               MDR_out = 1'b1;
               g_in    = rd_oh;
            end
            ST_S1: begin
               g_out        = rd_oh;
               MDR_EN_write = 1'b1;
            end
            ST_S2: mem_EN = 1'b1;
            ST_I0: P1_in = 1'b1;
            ST_I1: begin
               P1_out = 1'b1;
               g_in   = rd_oh;
            end
            ST_O0: begin
               g_out = rd_oh;
               P0_in = 1'b1;
            end
            ST_M0: begin
               immediate_out = 1'b1;
               g_in          = rd_oh;
            end
            default: ;
         endcase
      end
   end

   assign G0_in  = g_in[0];
   assign G1_in  = g_in[1];
   assign G2_in  = g_in[2];
   assign G3_in  = g_in[3];
   assign G0_out = g_out[0];
   assign G1_out = g_out[1];
   assign G2_out = g_out[2];
   assign G3_out = g_out[3];
   assign P0_out = 1'b0;

endmodule
